// File: rtl/fp_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pkg
// Purpose  : Shared types, constants and helper functions for fp_addsub_pipe.
// Revision : 1.0 - initial release
// ============================================================================
package fp_addsub_pkg;

    localparam int GRS_W          = 3;
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

    typedef enum logic [1:0] {NORMAL, ZERO, INF, NAN} fp_class_e;

    function automatic int word_w(input int e, input int m);
        return 1 + e + m;
    endfunction

    // Canonical quiet NaN, right-aligned in a 64-bit container.
    function automatic logic [63:0] qnan_bits(input int e, input int m);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < e; i++) v[m+i] = 1'b1;
        v[m-1] = 1'b1;
        return v;
    endfunction

    // Leading zeros of the low w bits of v.
    function automatic int lzc(input logic [63:0] v, input int w);
        int   n;
        logic done;
        n    = 0;
        done = 1'b0;
        for (int i = 63; i >= 0; i--) begin
            if (i < w && !done) begin
                if (v[i]) done = 1'b1;
                else      n    = n + 1;
            end
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fp_addsub_if.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_if
// Purpose  : Operand/result bundle for fp_addsub_pipe (flags under FP_ADDSUB_FLAGS_EN).
// Revision : 1.0 - initial release
// ============================================================================
interface fp_addsub_if #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
);
    localparam int W = fp_addsub_pkg::word_w(EXP_W, MAN_W);

    logic         valid_in;
    logic         sub_in;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         valid_out;
    logic [W-1:0] sum_out;
`ifdef FP_ADDSUB_FLAGS_EN
    logic [3:0]   flags_out;

    modport master (output valid_in, sub_in, a_in, b_in, input valid_out, sum_out, flags_out);
    modport slave  (input valid_in, sub_in, a_in, b_in, output valid_out, sum_out, flags_out);
`else
    modport master (output valid_in, sub_in, a_in, b_in, input valid_out, sum_out);
    modport slave  (input valid_in, sub_in, a_in, b_in, output valid_out, sum_out);
`endif
endinterface
`default_nettype wire

// File: rtl/fp_delay_line.sv
`default_nettype none
// ============================================================================
// Module   : fp_delay_line
// Purpose  : DEPTH-stage async-reset register chain used to balance latency.
// Revision : 1.0 - initial release
// ============================================================================
module fp_delay_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] i_d,
    output logic      [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_q = r_stage[DEPTH-1];
endmodule
`default_nettype wire

// File: rtl/fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fp_addsub_pipe
// Purpose  : 5-stage pipelined FP add/sub, RNE, FTZ, plus EXTRA_DELAY output
//            stages. Define FP_ADDSUB_FLAGS_EN to add flags_out.
// Revision : 1.0 - initial release
// ============================================================================
module fp_addsub_pipe
    import fp_addsub_pkg::*;
#(
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int EXTRA_DELAY = 3
) (
    input  wire logic  clock,
    input  wire logic  reset,
    fp_addsub_if.slave bus
);
    localparam int                c_W      = word_w(EXP_W, MAN_W);
    localparam int                c_SW     = MAN_W + 1 + GRS_W;
    localparam int                c_XW     = EXP_W + 2;
    localparam logic [63:0]       c_QNAN64 = qnan_bits(EXP_W, MAN_W);
    localparam logic [c_W-1:0]    c_QNAN   = c_QNAN64[c_W-1:0];
    localparam logic [EXP_W:0]    c_SHMAX  = (EXP_W+1)'(MAN_W + 3);

    function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
        if (e == '1)      return (f != '0) ? NAN : INF;
        else if (e == '0) return ZERO;
        else              return NORMAL;
    endfunction

    // ---------------- S1: unpack, specials, swap ----------------
    logic               w_sa, w_sb, w_b_big;
    logic [EXP_W-1:0]   w_ea, w_eb;
    logic [MAN_W-1:0]   w_fa, w_fb;
    fp_class_e          w_ca, w_cb;
    logic               w1_idle;
    logic [c_W-1:0]     w1_spec;

    assign w_sa    = bus.a_in[c_W-1];
    assign w_sb    = bus.b_in[c_W-1] ^ bus.sub_in;
    assign w_ea    = bus.a_in[c_W-2:MAN_W];
    assign w_eb    = bus.b_in[c_W-2:MAN_W];
    assign w_fa    = bus.a_in[MAN_W-1:0];
    assign w_fb    = bus.b_in[MAN_W-1:0];
    assign w_ca    = classify(w_ea, w_fa);
    assign w_cb    = classify(w_eb, w_fb);
    assign w_b_big = {w_eb, w_fb} > {w_ea, w_fa};

    always_comb begin
        w1_idle = 1'b1;
        w1_spec = c_QNAN;
        if (w_ca == NAN || w_cb == NAN) begin
            w1_spec = c_QNAN;
        end else if (w_ca == INF && w_cb == INF) begin
            if (w_sa == w_sb) w1_spec = {w_sa, w_ea, w_fa};
        end else if (w_ca == INF)  w1_spec = {w_sa, w_ea, w_fa};
        else if (w_cb == INF)      w1_spec = {w_sb, w_eb, w_fb};
        else if (w_ca == ZERO && w_cb == ZERO) w1_spec = {w_sa & w_sb, {(c_W-1){1'b0}}};
        else if (w_ca == ZERO)     w1_spec = {w_sb, w_eb, w_fb};
        else if (w_cb == ZERO)     w1_spec = {w_sa, w_ea, w_fa};
        else                       w1_idle = 1'b0;
    end

    // ---------------- S2..S5 combinational ----------------
    logic [EXP_W:0]     w2_sh;
    logic [c_SW-1:0]    w2_ext, w2_shf, w2_lost;
    logic [c_SW:0]      w3_sum;
    logic               w4_idle, w4_uf;
    logic [c_W-1:0]     w4_spec;
    logic [c_SW-1:0]    w4_man;
    logic [EXP_W:0]     w4_exp;
    logic signed [c_XW-1:0] w4_xexp;
    int                 w4_lz;
    logic               w5_up, w5_of;
    logic [MAN_W+1:0]   w5_rnd;
    logic [EXP_W:0]     w5_exp;
    logic [MAN_W-1:0]   w5_frac;
    logic [c_W-1:0]     w5_sum;

    logic               r1_valid, r1_idle, r1_sign, r1_sub;
    logic [c_W-1:0]     r1_spec;
    logic [EXP_W-1:0]   r1_exp;
    logic [MAN_W:0]     r1_manl, r1_mans;
    logic [EXP_W:0]     r1_diff;
    logic               r2_valid, r2_idle, r2_sign, r2_sub;
    logic [c_W-1:0]     r2_spec;
    logic [EXP_W-1:0]   r2_exp;
    logic [c_SW-1:0]    r2_manl, r2_mans;
    logic               r3_valid, r3_idle, r3_sign;
    logic [c_W-1:0]     r3_spec;
    logic [EXP_W-1:0]   r3_exp;
    logic [c_SW:0]      r3_sum;
    logic               r4_valid, r4_idle, r4_sign;
    logic [c_W-1:0]     r4_spec;
    logic [EXP_W:0]     r4_exp;
    logic [c_SW-1:0]    r4_man;
    logic               r5_valid;
    logic [c_W-1:0]     r5_sum;

    // Bits shifted past the sticky position are folded into it.
    assign w2_sh   = (r1_diff > c_SHMAX) ? c_SHMAX : r1_diff;
    assign w2_ext  = {r1_mans, {GRS_W{1'b0}}};
    assign w2_shf  = w2_ext >> w2_sh;
    assign w2_lost = w2_ext & ~({c_SW{1'b1}} << w2_sh);

    assign w3_sum = r2_sub ? ({1'b0, r2_manl} - {1'b0, r2_mans})
                           : ({1'b0, r2_manl} + {1'b0, r2_mans});

    always_comb begin
        w4_idle = r3_idle;
        w4_spec = r3_spec;
        w4_uf   = 1'b0;
        w4_man  = r3_sum[c_SW-1:0];
        w4_exp  = {1'b0, r3_exp};
        w4_lz   = 0;
        w4_xexp = '0;
        if (!r3_idle) begin
            if (r3_sum[c_SW]) begin
                w4_man = {r3_sum[c_SW:2], r3_sum[1] | r3_sum[0]};
                w4_exp = {1'b0, r3_exp} + 1'b1;
            end else if (r3_sum == '0) begin
                w4_idle = 1'b1;
                w4_spec = '0;
            end else begin
                w4_lz   = lzc(64'(r3_sum[c_SW-1:0]), c_SW);
                w4_man  = r3_sum[c_SW-1:0] << w4_lz;
                w4_xexp = $signed({2'b00, r3_exp}) - $signed(c_XW'(w4_lz));
                if (w4_xexp <= 0) begin
                    w4_idle = 1'b1;
                    w4_spec = {r3_sign, {(c_W-1){1'b0}}};
                    w4_uf   = 1'b1;
                end else begin
                    w4_exp = w4_xexp[EXP_W:0];
                end
            end
        end
    end

    assign w5_up   = r4_man[2] & (r4_man[1] | r4_man[0] | r4_man[3]);
    assign w5_rnd  = {1'b0, r4_man[c_SW-1:GRS_W]} + (MAN_W+2)'(w5_up);
    assign w5_exp  = r4_exp + (EXP_W+1)'(w5_rnd[MAN_W+1]);
    assign w5_frac = w5_rnd[MAN_W+1] ? w5_rnd[MAN_W:1] : w5_rnd[MAN_W-1:0];
    assign w5_of   = !r4_idle && (w5_exp >= {1'b0, {EXP_W{1'b1}}});
    assign w5_sum  = r4_idle ? r4_spec
                   : w5_of   ? {r4_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                   :           {r4_sign, w5_exp[EXP_W-1:0], w5_frac};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r1_valid <= 1'b0; r1_idle <= 1'b0; r1_sign <= 1'b0; r1_sub <= 1'b0;
            r1_spec  <= '0;   r1_exp  <= '0;   r1_manl <= '0;   r1_mans <= '0; r1_diff <= '0;
            r2_valid <= 1'b0; r2_idle <= 1'b0; r2_sign <= 1'b0; r2_sub <= 1'b0;
            r2_spec  <= '0;   r2_exp  <= '0;   r2_manl <= '0;   r2_mans <= '0;
            r3_valid <= 1'b0; r3_idle <= 1'b0; r3_sign <= 1'b0;
            r3_spec  <= '0;   r3_exp  <= '0;   r3_sum  <= '0;
            r4_valid <= 1'b0; r4_idle <= 1'b0; r4_sign <= 1'b0;
            r4_spec  <= '0;   r4_exp  <= '0;   r4_man  <= '0;
            r5_valid <= 1'b0; r5_sum  <= '0;
        end else begin
            r1_valid <= bus.valid_in;
            r1_idle  <= w1_idle;
            r1_spec  <= w1_spec;
            r1_sub   <= w_sa ^ w_sb;
            r1_sign  <= w_b_big ? w_sb : w_sa;
            r1_exp   <= w_b_big ? w_eb : w_ea;
            r1_manl  <= w_b_big ? {1'b1, w_fb} : {1'b1, w_fa};
            r1_mans  <= w_b_big ? {1'b1, w_fa} : {1'b1, w_fb};
            r1_diff  <= w_b_big ? ({1'b0, w_eb} - {1'b0, w_ea}) : ({1'b0, w_ea} - {1'b0, w_eb});

            r2_valid <= r1_valid; r2_idle <= r1_idle; r2_spec <= r1_spec;
            r2_sign  <= r1_sign;  r2_sub  <= r1_sub;  r2_exp  <= r1_exp;
            r2_manl  <= {r1_manl, {GRS_W{1'b0}}};
            r2_mans  <= {w2_shf[c_SW-1:1], w2_shf[0] | (|w2_lost)};

            r3_valid <= r2_valid; r3_idle <= r2_idle; r3_spec <= r2_spec;
            r3_sign  <= r2_sign;  r3_exp  <= r2_exp;  r3_sum  <= w3_sum;

            r4_valid <= r3_valid; r4_idle <= w4_idle; r4_spec <= w4_spec;
            r4_sign  <= r3_sign;  r4_exp  <= w4_exp;  r4_man  <= w4_man;

            r5_valid <= r4_valid;
            r5_sum   <= w5_sum;
        end
    end

`ifdef FP_ADDSUB_FLAGS_EN
    localparam int c_DW = 1 + 4 + c_W;
    logic       r4_uf;
    logic [3:0] r5_flags, w5_flags;

    always_comb begin
        w5_flags                 = '0;
        w5_flags[FLAG_INVALID]   = r4_idle && (r4_spec[c_W-2:MAN_W] == '1) && (r4_spec[MAN_W-1:0] != '0);
        w5_flags[FLAG_OVERFLOW]  = w5_of;
        w5_flags[FLAG_UNDERFLOW] = r4_uf;
        w5_flags[FLAG_INEXACT]   = (!r4_idle && (|r4_man[GRS_W-1:0])) | w5_of | r4_uf;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r4_uf    <= 1'b0;
            r5_flags <= '0;
        end else begin
            r4_uf    <= w4_uf;
            r5_flags <= w5_flags;
        end
    end

    logic [c_DW-1:0] w_dly_d, w_dly_q;
    assign w_dly_d = {r5_valid, r5_flags, r5_sum};
    assign {bus.valid_out, bus.flags_out, bus.sum_out} = w_dly_q;
`else
    localparam int c_DW = 1 + c_W;
    logic unused_uf;
    assign unused_uf = w4_uf;

    logic [c_DW-1:0] w_dly_d, w_dly_q;
    assign w_dly_d = {r5_valid, r5_sum};
    assign {bus.valid_out, bus.sum_out} = w_dly_q;
`endif

    generate
        if (EXTRA_DELAY == 0) begin : g_nodly
            assign w_dly_q = w_dly_d;
        end else begin : g_dly
            fp_delay_line #(
                .WIDTH (c_DW),
                .DEPTH (EXTRA_DELAY)
            ) u_dly (
                .clock (clock),
                .reset (reset),
                .i_d   (w_dly_d),
                .o_q   (w_dly_q)
            );
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fp_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_addsub_pipe
// Purpose  : Directed and streamed checks of fp_addsub_pipe (single + half).
// Revision : 1.0 - initial release
// ============================================================================
module tb_fp_addsub_pipe;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    fp_addsub_if #(.EXP_W(8), .MAN_W(23)) if_s ();
    fp_addsub_if #(.EXP_W(5), .MAN_W(10)) if_h ();

    fp_addsub_pipe #(.EXP_W(8), .MAN_W(23), .EXTRA_DELAY(3)) u_dut_s (
        .clock (clock), .reset (reset), .bus (if_s.slave));
    fp_addsub_pipe #(.EXP_W(5), .MAN_W(10), .EXTRA_DELAY(0)) u_dut_h (
        .clock (clock), .reset (reset), .bus (if_h.slave));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Single -> double is exact; sums of the bounded-exponent operands are exact in double.
    function automatic real s2r(input logic [31:0] x);
        logic [10:0] e;
        e = 11'(x[30:23]) - 11'd127 + 11'd1023;
        return $bitstoreal({x[31], e, x[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2s(input real r);
        logic [63:0] d;
        int          e;
        logic [24:0] m;
        logic [28:0] rem;
        d = $realtobits(r);
        if (d[62:0] == '0) return 32'h0;
        e   = int'(d[62:52]) - 1023 + 127;
        m   = {1'b0, 1'b1, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && m[0])) m = m + 1'b1;
        if (m[24]) begin
            m = m >> 1;
            e = e + 1;
        end
        return {d[63], e[7:0], m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        e = 8'($urandom_range(135, 120));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] want, input logic [3:0] wflags);
        int          lat, pulses;
        logic [31:0] got;
        logic [3:0]  gflags;
        @(negedge clock);
        if_s.valid_in = 1'b1; if_s.sub_in = s; if_s.a_in = a; if_s.b_in = b;
        @(negedge clock);
        if_s.valid_in = 1'b0;
        lat = 0; pulses = 0; got = '0; gflags = '0;
        for (int c = 1; c <= 16; c++) begin
            if (if_s.valid_out) begin
                pulses++;
                if (pulses == 1) begin
                    lat = c;
                    got = if_s.sum_out;
`ifdef FP_ADDSUB_FLAGS_EN
                    gflags = if_s.flags_out;
`endif
                end
            end
            @(negedge clock);
        end
        chk({tag, "_lat"}, 64'(lat), 64'd8);
        chk({tag, "_n"}, 64'(pulses), 64'd1);
        chk(tag, 64'(got), 64'(want));
`ifdef FP_ADDSUB_FLAGS_EN
        chk({tag, "_flg"}, 64'(gflags), 64'(wflags));
`endif
    endtask

    logic [31:0] sa [20];
    logic [31:0] sb [20];
    logic [31:0] sw [20];
    logic        ss [20];
    int          k, first, last, lat, cnt;
    logic [15:0] hgot;

    initial begin
        if_s.valid_in = 1'b0; if_s.sub_in = 1'b0; if_s.a_in = '0; if_s.b_in = '0;
        if_h.valid_in = 1'b0; if_h.sub_in = 1'b0; if_h.a_in = '0; if_h.b_in = '0;
        @(negedge clock); @(negedge clock);
        chk("rst_vout", 64'(if_s.valid_out), 64'd0);
        chk("rst_sum",  64'(if_s.sum_out),   64'd0);
        chk("rst_vout_h", 64'(if_h.valid_out), 64'd0);
        reset = 1'b0;

        run_op("add_1p2",   32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000);
        run_op("sub_1m1",   32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000);
        run_op("neg_zeros", 32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000);
        run_op("rne_tie",   32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001);
        run_op("rne_up",    32'h3F800000, 32'h34400000, 1'b0, 32'h3F800002, 4'b0001);
        run_op("inf_m_inf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'b1000);
        run_op("overflow",  32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101);
        run_op("nan_p1",    32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000);

        // Half precision, no trailing delay
        @(negedge clock);
        if_h.valid_in = 1'b1; if_h.sub_in = 1'b0; if_h.a_in = 16'h3C00; if_h.b_in = 16'h4000;
        @(negedge clock);
        if_h.valid_in = 1'b0;
        lat = 0; hgot = '0;
        for (int c = 1; c <= 12; c++) begin
            if (if_h.valid_out && lat == 0) begin
                lat  = c;
                hgot = if_h.sum_out;
            end
            @(negedge clock);
        end
        chk("half_lat", 64'(lat), 64'd5);
        chk("half_sum", 64'(hgot), 64'h4200);

        // Back-to-back stream against the double-precision reference
        for (int i = 0; i < 20; i++) begin
            sa[i] = rnd_fp();
            sb[i] = rnd_fp();
            ss[i] = 1'($urandom_range(1, 0));
            sw[i] = r2s(s2r(sa[i]) + (ss[i] ? -s2r(sb[i]) : s2r(sb[i])));
        end
        k = 0; first = -1; last = -1;
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    @(negedge clock);
                    if_s.valid_in = 1'b1; if_s.sub_in = ss[i]; if_s.a_in = sa[i]; if_s.b_in = sb[i];
                end
                @(negedge clock);
                if_s.valid_in = 1'b0;
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge clock);
                    if (if_s.valid_out) begin
                        if (k < 20) chk($sformatf("stream%0d", k), 64'(if_s.sum_out), 64'(sw[k]));
                        if (first < 0) first = c;
                        last = c;
                        k++;
                    end
                end
            end
        join
        chk("stream_cnt",  64'(k), 64'd20);
        chk("stream_span", 64'(last - first), 64'd19);

        // Reset while results are in flight
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if_s.valid_in = 1'b1; if_s.sub_in = 1'b0; if_s.a_in = rnd_fp(); if_s.b_in = rnd_fp();
        end
        #1;
        chk("midrst_pre", 64'(if_s.valid_out), 64'd1);
        reset = 1'b1;
        #1;
        chk("midrst_vout", 64'(if_s.valid_out), 64'd0);
        chk("midrst_sum",  64'(if_s.sum_out),   64'd0);
        if_s.valid_in = 1'b0;
        @(negedge clock); @(negedge clock);
        reset = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock);
            if (if_s.valid_out) cnt++;
        end
        chk("midrst_stale", 64'(cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fp_addsub_pipe.md
Name: fp_addsub_pipe

Overview:
- Parametrised, fully pipelined floating-point add/subtract unit. Successor to the fixed 32-bit adder chain in the HCORDIC z-path.
- Adds configurable exponent/mantissa widths, an add/subtract mode, a valid tag, round-to-nearest-even and a configurable trailing delay line.
- Sits in the CORDIC angle (z) datapath. Also serves as a generic FP adder for the x/y paths.

Parameters:
- EXP_W, 8: exponent field width.
- MAN_W, 23: stored fraction width, excluding the hidden bit.
- EXTRA_DELAY, 3: number of output register stages after pack. Range 0..8. Used to balance against the multiplier latency.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-high reset.
- valid_in, input, 1: operands valid this cycle.
- sub_in, input, 1: 0 computes a+b; 1 computes a-b.
- a_in, input, 1+EXP_W+MAN_W: operand A as {sign, exp, frac}, IEEE-754 style.
- b_in, input, 1+EXP_W+MAN_W: operand B, same format.
- valid_out, output, 1: result valid.
- sum_out, output, 1+EXP_W+MAN_W: result.

Behaviour:
- One clock; reset is asynchronous and active-high.
- Reset values: all pipeline registers, valid_out and sum_out are 0.
- Reset mid-operation discards every in-flight result. valid_out stays 0 until a new operand pair has traversed the full pipe.
- No backpressure: a new operand pair is accepted every cycle.
- Latency: exactly 5 + EXTRA_DELAY cycles from valid_in to valid_out. This is 8 by default.
- valid travels with its data. sum_out still updates when its valid bit is 0; the content is don't-care.
- Stage S1, unpack/special:
  - When sub_in=1, B's sign is inverted.
  - Specials are detected here: exp all-ones with frac≠0 is NaN; exp all-ones with frac=0 is Inf; exp=0 is zero. Subnormal inputs are flushed to signed zero.
  - A special result is fixed in this stage and bypasses the arithmetic via an idle flag.
  - Exponent difference is computed at EXP_W+1 bits. Operands are swapped so the larger magnitude is first.
- Stage S2, align:
  - The smaller significand is shifted right by the difference, saturated at MAN_W+3.
  - Guard, round and sticky bits are kept. Sticky is the OR of all bits shifted out.
- Stage S3, add: significands are added or subtracted at MAN_W+5 bits. Effective subtract occurs when the signs differ.
- Stage S4, normalise:
  - Carry out causes a right shift by 1 and exp+1.
  - Otherwise a leading-zero count is taken, followed by a left shift and exponent decrement.
  - A zero sum gives +0. The exception is (-0)+(-0), which gives -0.
  - If the exponent drops to ≤0, the result flushes to signed zero.
- Stage S5, round/pack:
  - Round to nearest, ties to even.
  - A rounding carry renormalises and increments the exponent.
  - Exponent ≥ all-ones saturates to signed Inf.
- Special results:
  - Any NaN operand gives the canonical qNaN: sign 0, exp all-ones, frac MSB 1, rest 0.
  - Inf + (-Inf), after the effective sign is applied, gives the canonical qNaN.
  - Inf + finite gives that Inf.
  - x + 0 gives x; a flushed subnormal counts as 0.
- Delay line: EXTRA_DELAY register stages, each holding {valid, sum}. When EXTRA_DELAY=0, the outputs come straight from the S5 registers.

Optional Feature:
- FP_ADDSUB_FLAGS_EN defined:
  - Adds output flags_out [3:0] = {invalid, overflow, underflow, inexact}. It is aligned with valid_out and resets to 0.
  - invalid: a NaN or Inf-Inf result. overflow: saturation to Inf. underflow: flush-to-zero of a nonzero result. inexact: G|R|S was nonzero, or overflow or underflow occurred.
- FP_ADDSUB_FLAGS_EN undefined: the port is absent and no flag logic is built. Result datapath and latency are identical in both builds.

Decomposition:
- Package fp_addsub_pkg holds:
  - a function for the total word width;
  - a function for the canonical qNaN constant for given EXP_W/MAN_W;
  - a special-class enum {NORMAL, ZERO, INF, NAN};
  - localparams for GRS width (3) and flag bit positions.
- One sub-module: fp_delay_line, with parameters WIDTH and DEPTH. It is an async-reset register chain and is used for the trailing EXTRA_DELAY stages.
- The leading-zero count stays as a function inside the package.

Test Plan:
- Latency/basic: single valid_in with a=0x3F800000, b=0x40000000, sub=0 → valid_out exactly 8 cycles later, sum=0x40400000. No other valid_out pulse.
- Subtract/zero: a=0x3F800000, b=0x3F800000, sub=1 → 0x00000000. Also a=0x80000000, b=0x80000000, sub=0 → 0x80000000.
- Rounding:
  - 0x3F800000 + 0x33800000 (2^-24) → 0x3F800000 (tie to even).
  - 0x3F800000 + 0x34400000 (3·2^-24) → 0x3F800002.
- Specials:
  - 0x7F800000 + 0xFF800000 → 0x7FC00000.
  - 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000 (overflow flag set when enabled).
  - NaN + 1.0 → 0x7FC00000.
- Throughput and reset:
  - Stream 20 back-to-back random pairs → outputs match the reference model in order, one per cycle.
  - Assert reset mid-stream → valid_out drops immediately and no stale result appears afterwards.
- Parametrisation: EXP_W=5, MAN_W=10, EXTRA_DELAY=0. Input 0x3C00+0x4000 (half 1.0+2.0) → 0x4200 after exactly 5 cycles.
